// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker
//   Receive-side checker for an 8-bit LFSR PRNG stream, polynomial
//   x^8+x^6+x^5+x^4+1, next(x) = {x[6:0], x[7]^x[5]^x[4]^x[3]}.
//   The checker seeds its predictor from a received word. It confirms lock
//   after LOCK_THRESH consecutive matches. While locked it counts mismatches.
//
//   State table:
//     state     | meaning
//     ST_SEARCH | waiting for a nonzero word to seed the predictor
//     ST_VERIFY | seeded; counting consecutive matches toward lock
//     ST_LOCKED | predictor free-runs; mismatches are pulsed and counted
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous reset, active-high
//     in_valid   in   in_data is sampled this cycle
//     in_data    in   received LFSR word
//     clr_cnt    in   synchronous clear of err_count (wins over an increment)
//     locked     out  registered, high while in ST_LOCKED
//     err_pulse  out  one-cycle pulse for a mismatch sampled while locked
//     err_count  out  saturating count of locked mismatches
//     expected   out  value the next valid word must equal
//
//   Configuration macro: LFSR_CHK_AUTO_RESYNC_EN
//     When this macro is defined, UNLOCK_THRESH consecutive locked mismatches
//     return the FSM to ST_SEARCH.
//     When it is undefined, ST_LOCKED is held until reset and the miss-run
//     counter is not built.
module lfsr_seq_checker #(
  parameter int LOCK_THRESH   = 4,
  parameter int UNLOCK_THRESH = 3,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       expected
);

  // Both thresholds must fit the 4-bit run counters.
  if (LOCK_THRESH < 1 || LOCK_THRESH > 15) begin : g_bad_lock_thresh
    $error("LOCK_THRESH must be in 1..15");
  end
  if (UNLOCK_THRESH < 1 || UNLOCK_THRESH > 15) begin : g_bad_unlock_thresh
    $error("UNLOCK_THRESH must be in 1..15");
  end

  localparam logic [3:0] LOCK_T = 4'(LOCK_THRESH);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       expected_q, expected_d;
  logic [3:0]       match_run_q, match_run_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             hit;

`ifdef LFSR_CHK_AUTO_RESYNC_EN
  localparam logic [3:0] UNLOCK_T = 4'(UNLOCK_THRESH);
  logic [3:0] miss_run_q, miss_run_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) miss_run_q <= '0;
    else     miss_run_q <= miss_run_d;
  end
`endif

  // 8'h00 is the LFSR lock-up state, so it can never be a valid match.
  assign hit = (in_data == expected_q) && (in_data != 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SEARCH;
      expected_q  <= 8'h00;
      match_run_q <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_run_q <= match_run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_run_d = match_run_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
`ifdef LFSR_CHK_AUTO_RESYNC_EN
    miss_run_d  = miss_run_q;
`endif

    if (in_valid) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (in_data != 8'h00) begin
            expected_d  = lfsr_next(in_data);
            match_run_d = '0;
            state_d     = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (hit) begin
            expected_d  = lfsr_next(in_data);
            match_run_d = match_run_q + 4'd1;
            if (match_run_d == LOCK_T) state_d = ST_LOCKED;
          end else if (in_data != 8'h00) begin
            expected_d  = lfsr_next(in_data);
            match_run_d = '0;
          end else begin
            state_d = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          // Free-run from the predictor so that a corrupted word cannot reseed.
          expected_d = lfsr_next(expected_q);
          if (!hit) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
`ifdef LFSR_CHK_AUTO_RESYNC_EN
            if (miss_run_q != 4'hF) miss_run_d = miss_run_q + 4'd1;
            if (miss_run_d == UNLOCK_T) begin
              state_d     = ST_SEARCH;
              miss_run_d  = '0;
              match_run_d = '0;
            end
`endif
          end
`ifdef LFSR_CHK_AUTO_RESYNC_EN
          else begin
            miss_run_d = '0;
          end
`endif
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    if (clr_cnt) err_count_d = '0;

    locked_d = (state_d == ST_LOCKED);
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign expected  = expected_q;

endmodule
